calc_program_feeder: RTL and testbench

Transmit-side partner of the 16-slot calculator core. It buffers a 16-instruction program written by a host over a valid/ready port. On start, it resets the calculator and streams the program on the calculator's 18-bit DIN bus, one word per cycle. It then waits out the calculator's execution window and signals done.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/calc_program_feeder_if.sv | 29 ++
 rtl/calc_prog_buffer.sv | 20 ++
 rtl/calc_program_feeder.sv | 126 ++++++++++++
 tb/tb_calc_program_feeder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: widths, opcodes, the packed instruction word
// and the feeder FSM states.
package calc_pkg;
  localparam int N_INSTR     = 16;
  localparam int OP_W        = 2;
  localparam int OPND_W      = 8;
  localparam int W           = OP_W + 2 * OPND_W;
  localparam int EXEC_CYCLES = 17;
  localparam int IDX_W       = $clog2(N_INSTR);
  localparam int FILL_W      = $clog2(N_INSTR + 1);

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opcode_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_STREAM = 2'd2,
    S_WAIT   = 2'd3
  } feeder_state_e;

  function automatic logic [W-1:0] pack_instr(input logic [OP_W-1:0] op,
                                              input logic [OPND_W-1:0] a,
                                              input logic [OPND_W-1:0] b);
    return {op, a, b};
  endfunction

  function automatic instr_t unpack_instr(input logic [W-1:0] w);
    return instr_t'(w);
  endfunction
endpackage

// File: rtl/calc_program_feeder_if.sv
// Host-load port plus calculator-facing outputs of the program feeder.
// The host/bench side is master, the feeder is slave.
interface calc_program_feeder_if;
  import calc_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [OP_W-1:0]   wr_op;
  logic [OPND_W-1:0] wr_a;
  logic [OPND_W-1:0] wr_b;
  logic              clear;
  logic              start;
  logic [W-1:0]      dout;
  logic              calc_reset;
  logic [FILL_W-1:0] fill;
  logic              busy;
  logic              done;
  logic              start_err;

  modport master (
    output wr_valid, wr_op, wr_a, wr_b, clear, start,
    input  wr_ready, dout, calc_reset, fill, busy, done, start_err
  );

  modport slave (
    input  wr_valid, wr_op, wr_a, wr_b, clear, start,
    output wr_ready, dout, calc_reset, fill, busy, done, start_err
  );
endinterface

// File: rtl/calc_prog_buffer.sv
// Program store: N_INSTR x W register file, one write port, combinational read.
// Contents are not reset; the feeder tracks validity through its fill count.
module calc_prog_buffer
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic [IDX_W-1:0] rd_addr_i,
  output logic [W-1:0]     rd_data_o
);
  logic [W-1:0] mem_q [N_INSTR];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/calc_program_feeder.sv
// Buffers a 16-word program from the host, then resets the calculator, streams
// the program one word per cycle and waits out execution before pulsing done.
module calc_program_feeder
  import calc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  calc_program_feeder_if.slave  bus
);
  localparam int WCNT_W = $clog2(EXEC_CYCLES + 1);

  feeder_state_e     state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0]  idx_q, idx_d, rd_addr;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [W-1:0]      dout_q, dout_d, rd_data;
  logic              calc_reset_q, calc_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_err_q, start_err_d;
  logic              wr_ready, wr_en;

  assign wr_ready = (state_q == S_IDLE) && (fill_q < FILL_W'(N_INSTR));

  calc_prog_buffer u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (fill_q[IDX_W-1:0]),
    .wr_data_i (pack_instr(bus.wr_op, bus.wr_a, bus.wr_b)),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Outputs are registered, so each branch prepares what the next state shows.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    idx_d        = idx_q;
    wcnt_d       = wcnt_q;
    dout_d       = '0;
    calc_reset_d = calc_reset_q;
    done_d       = 1'b0;
    start_err_d  = 1'b0;
    wr_en        = 1'b0;
    rd_addr      = idx_q;
    unique case (state_q)
      S_IDLE: begin
        rd_addr = '0;
        if (bus.clear) begin
          fill_d = '0;
        end else if (bus.wr_valid && wr_ready) begin
          wr_en  = 1'b1;
          fill_d = fill_q + 1'b1;
        end
        if (bus.start) begin
          if (!bus.clear && fill_q == FILL_W'(N_INSTR)) begin
            state_d      = S_ARM;
            calc_reset_d = 1'b1;
            dout_d       = rd_data;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        state_d      = S_STREAM;
        idx_d        = '0;
        calc_reset_d = 1'b0;
        rd_addr      = '0;
        dout_d       = rd_data;
      end
      S_STREAM: begin
        if (idx_q == IDX_W'(N_INSTR - 1)) begin
          state_d = S_WAIT;
          wcnt_d  = WCNT_W'(EXEC_CYCLES);
        end else begin
          idx_d   = idx_q + 1'b1;
          rd_addr = idx_q + 1'b1;
          dout_d  = rd_data;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WCNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fill_q       <= '0;
      idx_q        <= '0;
      wcnt_q       <= '0;
      dout_q       <= '0;
      calc_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      dout_q       <= dout_d;
      calc_reset_q <= calc_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_err_q  <= start_err_d;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.dout       = dout_q;
  assign bus.calc_reset = calc_reset_q;
  assign bus.fill       = fill_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.start_err  = start_err_q;
endmodule

// File: tb/tb_calc_program_feeder.sv
// Directed bench for calc_program_feeder with a small behavioural calculator
// attached to dout/calc_reset for the loopback runs.
module tb_calc_program_feeder;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  calc_program_feeder_if bus ();
  calc_program_feeder dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         clr;
    logic         st;
    int           e_fill;
    logic         e_rdy;
    logic         e_err;
  } vec_t;
  vec_t vt [15];

  int lp_a  [16] = '{3, 2, 4, 20, 100, 50, 12, 9, 0, 0, 15, 255, 200, 10, 3, 7};
  int lp_b  [16] = '{5, 9, 6, 3, 27, 20, 12, 9, 0, 1, 16, 5, 55, 10, 7, 2};
  int e_res [16] = '{8, 7, 24, 6, 127, 30, 144, 1, 0, 1, 240, 51, 255, 0, 21, 3};
  int e_neg [16] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] word(input int k);
    logic [OP_W-1:0]   op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    op = OP_W'(k % 4);
    a  = OPND_W'(k);
    b  = OPND_W'(255 - k);
    return {op, a, b};
  endfunction

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic clr,
                              input logic st, input int f, input logic rdy, input logic err);
    vec_t r;
    r.v = v; r.d = d; r.clr = clr; r.st = st; r.e_fill = f; r.e_rdy = rdy; r.e_err = err;
    return r;
  endfunction

  function automatic int alu_res(input logic [W-1:0] w);
    instr_t i;
    i = unpack_instr(w);
    case (opcode_e'(i.op))
      OP_ADD:  return int'(i.a) + int'(i.b);
      OP_SUB:  return (i.a >= i.b) ? int'(i.a) - int'(i.b) : int'(i.b) - int'(i.a);
      OP_MUL:  return int'(i.a) * int'(i.b);
      default: return (i.b == 0) ? 0 : int'(i.a) / int'(i.b);
    endcase
  endfunction

  function automatic int alu_neg(input logic [W-1:0] w);
    instr_t i;
    i = unpack_instr(w);
    return (opcode_e'(i.op) == OP_SUB && i.a < i.b) ? 1 : 0;
  endfunction

  // Calculator model: loads 16 words on the edges after its reset drops, then executes.
  logic [W-1:0] cmem [N_INSTR];
  logic [4:0]   cap_cnt = '0;
  logic [4:0]   exe_cnt = '0;
  int           res_q [$];
  int           neg_q [$];

  always @(posedge clk) begin
    if (bus.calc_reset) begin
      cap_cnt <= '0;
      exe_cnt <= '0;
    end else if (cap_cnt < 5'(N_INSTR)) begin
      cmem[cap_cnt[3:0]] <= bus.dout;
      cap_cnt <= cap_cnt + 1'b1;
    end else if (exe_cnt < 5'(N_INSTR)) begin
      res_q.push_back(alu_res(cmem[exe_cnt[3:0]]));
      neg_q.push_back(alu_neg(cmem[exe_cnt[3:0]]));
      exe_cnt <= exe_cnt + 1'b1;
    end
  end

  task automatic run_loopback(input string tag);
    int cyc;
    res_q.delete();
    neg_q.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 60) begin
      tick();
      cyc++;
    end
    chk({tag, "_done_seen"}, bus.done, 1'b1);
    chk({tag, "_res_count"}, res_q.size(), 16);
    for (int k = 0; k < 16 && k < res_q.size(); k++) begin
      chk($sformatf("%s_res%0d", tag, k), res_q[k], e_res[k]);
      chk($sformatf("%s_neg%0d", tag, k), neg_q[k], e_neg[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int done_cnt;
    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_op = '0; bus.wr_a = '0; bus.wr_b = '0;
    bus.clear = 1'b0; bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready", bus.wr_ready, 1'b1);
    chk("rst_dout", bus.dout, '0);
    chk("rst_calc_reset", bus.calc_reset, 1'b1);
    chk("rst_fill", bus.fill, '0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_start_err", bus.start_err, 1'b0);
    reset = 1'b0;

    // Load, short-program start, clear, clear-vs-write and clear-then-start.
    vt[0] = mk(0, '0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) vt[1 + k] = mk(1, word(k), 0, 0, k + 1, 1, 0);
    vt[6] = mk(0, '0, 0, 1, 5, 1, 1);
    vt[7] = mk(0, '0, 0, 0, 5, 1, 0);
    vt[8] = mk(0, '0, 1, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) vt[9 + k] = mk(1, word(k), 0, 0, k + 1, 1, 0);
    vt[12] = mk(1, 18'h3FFFF, 1, 0, 0, 1, 0);
    vt[13] = mk(0, '0, 0, 1, 0, 1, 1);
    vt[14] = mk(0, '0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      bus.wr_valid = vt[i].v;
      {bus.wr_op, bus.wr_a, bus.wr_b} = vt[i].d;
      bus.clear = vt[i].clr;
      bus.start = vt[i].st;
      tick();
      chk($sformatf("vec%0d_fill", i), bus.fill, vt[i].e_fill);
      chk($sformatf("vec%0d_wr_ready", i), bus.wr_ready, vt[i].e_rdy);
      chk($sformatf("vec%0d_start_err", i), bus.start_err, vt[i].e_err);
      chk($sformatf("vec%0d_busy", i), bus.busy, 1'b0);
      chk($sformatf("vec%0d_dout", i), bus.dout, '0);
    end
    bus.wr_valid = 1'b0; bus.clear = 1'b0; bus.start = 1'b0;
    chk("clear_blocks_slot3_write", dut.u_buf.mem_q[3], word(3));

    // Hold wr_valid for 20 cycles: only 16 writes land.
    for (int c = 0; c < 20; c++) begin
      bus.wr_valid = 1'b1;
      {bus.wr_op, bus.wr_a, bus.wr_b} = word(c);
      tick();
      chk($sformatf("burst%0d_fill", c), bus.fill, (c + 1 < 16) ? c + 1 : 16);
      chk($sformatf("burst%0d_wr_ready", c), bus.wr_ready, (c + 1 < 16) ? 1 : 0);
    end
    bus.wr_valid = 1'b0;

    // Full run; a stray start and clear mid-run must be ignored.
    bus.start = 1'b1;
    for (int n = 0; n <= 35; n++) begin
      tick();
      bus.start = (n == 4);
      bus.clear = (n == 9);
      chk($sformatf("run%0d_busy", n), bus.busy, (n < 34) ? 1 : 0);
      chk($sformatf("run%0d_calc_reset", n), bus.calc_reset, (n == 0) ? 1 : 0);
      chk($sformatf("run%0d_dout", n), bus.dout,
          (n == 0) ? word(0) : (n <= 16) ? word(n - 1) : '0);
      chk($sformatf("run%0d_done", n), bus.done, (n == 34) ? 1 : 0);
      chk($sformatf("run%0d_start_err", n), bus.start_err, 1'b0);
    end
    bus.start = 1'b0; bus.clear = 1'b0;
    chk("run_fill_kept", bus.fill, 16);

    // Loopback program through the calculator model, then rerun without reload.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("lb_cleared", bus.fill, 0);
    for (int k = 0; k < 16; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_op = OP_W'(k % 4);
      bus.wr_a  = OPND_W'(lp_a[k]);
      bus.wr_b  = OPND_W'(lp_b[k]);
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("lb_fill", bus.fill, 16);
    run_loopback("lb1");
    tick();
    run_loopback("lb2");
    tick();

    // Reset while streaming slot 7.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    chk("pre_rst_calc_reset", bus.calc_reset, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst_state", dut.state_q, S_IDLE);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_calc_reset", bus.calc_reset, 1'b1);
    chk("midrst_dout", bus.dout, '0);
    chk("midrst_fill", bus.fill, 0);
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_wr_ready", bus.wr_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
